// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential floating-point adder/subtractor.
// Word layout is {sign, exponent[EXP_W], mantissa[MAN_W]} with an implicit hidden bit.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4
    } state_e;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_flags_t;

    // Both constants come back in a 64-bit container; callers slice the low W bits.
    function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] fp_pos_inf(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Splits a floating-point word into its fields and special-value flags.
// Denormals report as zero, which is how the adder flushes them.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] word,
    output logic                 sign,
    output logic [EXP_W-1:0]     fld_exp,
    output logic [MAN_W-1:0]     fld_man,
    output fp_flags_t            flags
);

    assign sign    = word[EXP_W+MAN_W];
    assign fld_exp = word[EXP_W+MAN_W-1:MAN_W];
    assign fld_man = word[MAN_W-1:0];

    assign flags.is_zero = (fld_exp == '0);
    assign flags.is_inf  = (&fld_exp) && (fld_man == '0);
    assign flags.is_nan  = (&fld_exp) && (fld_man != '0);

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor: IDLE -> ALIGN -> ADD -> NORM(xk) -> ROUND.
// Define FP_ROUND_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sub,
    input  logic [EXP_W+MAN_W:0] dataa,
    input  logic [EXP_W+MAN_W:0] datab,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 done,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;   // {hidden, man, G, R, S}
    localparam int EW = EXP_W + 1;   // one spare bit so exponent increments never wrap
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [63:0]   NAN64   = fp_canon_nan(EXP_W, MAN_W);
    localparam logic [63:0]   INF64   = fp_pos_inf(EXP_W, MAN_W);
    localparam logic [W-1:0]  NAN_W   = NAN64[W-1:0];
    localparam logic [W-2:0]  INF_MAG = INF64[W-2:0];

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, fast_res_q, fast_res_d, result_q, result_d;
    logic            fast_q, fast_d, sign_q, sign_d, eff_sub_q, eff_sub_d, zero_q, zero_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [SW-1:0]   big_q, big_d, small_q, small_d;
    logic [SW:0]     sig_q, sig_d;
    logic            done_q, done_d, busy_q, busy_d;

    logic            sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    fp_flags_t       fa, fb;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .word(dataa), .sign(sa), .fld_exp(ea), .fld_man(ma), .flags(fa)
    );
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .word(datab), .sign(sb), .fld_exp(eb), .fld_man(mb), .flags(fb)
    );

    // Special-value fast path, evaluated on the raw inputs at capture.
    logic         sb_eff, fast_hit;
    logic [W-1:0] fast_val;
    assign sb_eff   = sb ^ sub;
    assign fast_hit = fa.is_nan | fb.is_nan | fa.is_inf | fb.is_inf | fa.is_zero | fb.is_zero;

    always_comb begin
        fast_val = '0;
        if (fa.is_nan || fb.is_nan)      fast_val = NAN_W;
        else if (fa.is_inf && fb.is_inf) fast_val = (sa != sb_eff) ? NAN_W : {sa, ea, ma};
        else if (fa.is_inf)              fast_val = {sa, ea, ma};
        else if (fb.is_inf)              fast_val = {sb_eff, eb, mb};
        else if (fa.is_zero && fb.is_zero) fast_val = {sa & sb_eff, {(W-1){1'b0}}};
        else if (fa.is_zero)             fast_val = {sb_eff, eb, mb};
        else                             fast_val = {sa, ea, ma};
    end

    // Alignment: order by magnitude, then shift the smaller significand right.
    logic            a_big;
    logic [EW-1:0]   exp_big, exp_small, diff;
    logic [SW-1:0]   small_full, small_aln, drop_mask;
    assign a_big      = a_q[W-2:0] >= b_q[W-2:0];
    assign exp_big    = a_big ? {1'b0, a_q[W-2:MAN_W]} : {1'b0, b_q[W-2:MAN_W]};
    assign exp_small  = a_big ? {1'b0, b_q[W-2:MAN_W]} : {1'b0, a_q[W-2:MAN_W]};
    assign diff       = exp_big - exp_small;
    assign small_full = {1'b1, (a_big ? b_q[MAN_W-1:0] : a_q[MAN_W-1:0]), 3'b000};

    always_comb begin
        drop_mask = '0;
        small_aln = {{(SW-1){1'b0}}, 1'b1};
        if (diff < EW'(SW)) begin
            drop_mask = ~({SW{1'b1}} << diff);
            small_aln = (small_full >> diff) | {{(SW-1){1'b0}}, |(small_full & drop_mask)};
        end
    end

    logic            inc;
    logic [MAN_W:0]  man_rnd;
    logic [EW-1:0]   exp_rnd;
`ifdef FP_ROUND_RNE_EN
    assign inc = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
`else
    assign inc = 1'b0;
`endif
    assign man_rnd = {1'b0, sig_q[SW-2:3]} + {{MAN_W{1'b0}}, inc};
    assign exp_rnd = exp_q + {{EXP_W{1'b0}}, man_rnd[MAN_W]};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        fast_d     = fast_q;
        fast_res_d = fast_res_q;
        sign_d     = sign_q;
        eff_sub_d  = eff_sub_q;
        zero_d     = zero_q;
        exp_d      = exp_q;
        big_d      = big_q;
        small_d    = small_q;
        sig_d      = sig_q;
        result_d   = result_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    a_d        = dataa;
                    b_d        = {sb_eff, datab[W-2:0]};
                    fast_d     = fast_hit;
                    fast_res_d = fast_val;
                    busy_d     = 1'b1;
                    state_d    = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (fast_q) begin
                    result_d = fast_res_q;
                    done_d   = 1'b1;
                    state_d  = ST_ROUND;
                end else begin
                    big_d     = {1'b1, (a_big ? a_q[MAN_W-1:0] : b_q[MAN_W-1:0]), 3'b000};
                    small_d   = small_aln;
                    exp_d     = exp_big;
                    sign_d    = a_big ? a_q[W-1] : b_q[W-1];
                    eff_sub_d = a_q[W-1] ^ b_q[W-1];
                    state_d   = ST_ADD;
                end
            end
            ST_ADD: begin
                sig_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                    : ({1'b0, big_q} + {1'b0, small_q});
                zero_d  = 1'b0;
                state_d = ST_NORM;
            end
            ST_NORM: begin
                if (sig_q[SW]) begin
                    sig_d   = {1'b0, sig_q[SW:2], sig_q[1] | sig_q[0]};
                    exp_d   = exp_q + 1'b1;
                    state_d = ST_ROUND;
                end else if (sig_q == '0) begin
                    zero_d  = 1'b1;
                    sign_d  = 1'b0;
                    state_d = ST_ROUND;
                end else if (!sig_q[SW-1]) begin
                    // Another shift would take the exponent to zero: flush instead.
                    if (exp_q <= EW'(1)) begin
                        zero_d  = 1'b1;
                        state_d = ST_ROUND;
                    end else begin
                        sig_d = sig_q << 1;
                        exp_d = exp_q - 1'b1;
                    end
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (done_q) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                    if (zero_q)                  result_d = {sign_q, {(W-1){1'b0}}};
                    else if (exp_rnd >= EXP_MAX) result_d = {sign_q, INF_MAG};
                    else result_d = {sign_q, exp_rnd[EXP_W-1:0],
                                     (man_rnd[MAN_W] ? {MAN_W{1'b0}} : man_rnd[MAN_W-1:0])};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            fast_q     <= 1'b0;
            fast_res_q <= '0;
            sign_q     <= 1'b0;
            eff_sub_q  <= 1'b0;
            zero_q     <= 1'b0;
            exp_q      <= '0;
            big_q      <= '0;
            small_q    <= '0;
            sig_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fast_q     <= fast_d;
            fast_res_q <= fast_res_d;
            sign_q     <= sign_d;
            eff_sub_q  <= eff_sub_d;
            zero_q     <= zero_d;
            exp_q      <= exp_d;
            big_q      <= big_d;
            small_q    <= small_d;
            sig_q      <= sig_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Parametrised multi-cycle IEEE-754 binary floating-point adder/subtractor; next generation of the team's single-precision adder.
- Adds: configurable exponent and mantissa widths, add/sub mode, Inf/NaN handling, overflow to Inf, guard/round/sticky bits, iterative normaliser, busy/done handshake and reset.
- Sits beside the other FPU blocks as a custom-instruction datapath: enable in, done out.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width; hidden bit is implicit. Word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  start pulse; sampled only while idle.
- sub  in  1  0 computes dataa+datab; 1 computes dataa-datab (datab sign inverted at capture).
- dataa  in  W  operand A.
- datab  in  W  operand B.
- result  out  W  registered result; holds its value until the next done.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high from the capture edge until the done edge, inclusive.

Behaviour:
- Reset: async, active-high, one clock (clk). result=0, done=0, busy=0, state=IDLE. Reset mid-operation aborts the operation, and no done follows.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND.
- IDLE, enable=1 (edge 0): capture operands, apply sub, classify, go to ALIGN, busy=1. enable while busy is ignored; no queueing.
- ALIGN (edge 1): order operands by magnitude {exp,man}. Shift the smaller significand right by the exponent difference into a (MAN_W+4)-bit field {hidden, man, G, R} plus sticky (OR of shifted-out bits). A difference above MAN_W+3 leaves sticky only.
- ADD (edge 2): same effective sign adds; different signs subtract smaller from larger. Result sign is the sign of the larger operand. Carry-out sets a carry flag.
- NORM (edges 3..3+k):
  - Carry: shift right once, sticky absorbs the dropped bit, exp+1, go to ROUND.
  - Hidden bit clear: shift left one bit per cycle, exp-1, stay in NORM. k = number of left shifts.
  - Zero sum: go to ROUND with the zero flag set.
- ROUND (edge 4+k): round the significand, then register result and set done=1 for one cycle. busy drops on the following edge and the FSM returns to IDLE.
- Latency: done goes high 4+k edges after capture. k ranges from 0 to MAN_W+1.
- Rounding carry out of the significand: exp+1, mantissa=0.
- Exponent reaching all-ones: ±Inf.
- Exponent underflow (<=0) during NORM: abort shifting and flush to signed zero.
- Exact cancellation: +0. (-0)+(-0): -0.
- Special fast path at capture: result is registered and done is pulsed on edge 1, with latency 1. This applies to:
  - Any NaN input: canonical quiet NaN {0, all-ones, 1, zeros}.
  - Inf-Inf with opposite effective signs: canonical NaN.
  - Inf with any finite operand: that Inf.
  - Either operand zero or denormal: denormals are treated as zero (flush-to-zero). The result is the other operand, sign-adjusted for sub. Both zero: the signed-zero rule above.
- Output denormals are never produced.

Optional Feature:
- FP_ROUND_RNE_EN defined: round-to-nearest-even from G/R/sticky. Increment when G&(R|S|lsb).
- Undefined: truncation (round toward zero). G/R/S are discarded, ROUND still takes one cycle, and latency is unchanged.

Decomposition:
- Package fp_pkg holds:
  - FSM state enum.
  - Canonical NaN and Inf constant functions of EXP_W/MAN_W.
  - Classification flag struct (is_zero, is_inf, is_nan).
- One sub-module, fp_classify (combinational): splits a word into sign/exp/man and flags. Instantiated twice.

Test Plan:
- 0x3F800000 + 0x40000000, sub=0 -> result 0x40400000, k=0, done 4 edges after capture, busy high throughout.
- 0x3F800000 - 0x3F400000 (sub=1) -> 0x3E800000, k=2, done at edge 6. Also 0x3F800000 + 0x3F800000 -> 0x40000000 via the carry path.
- 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even). 0x3F800000 + 0x33800001 -> 0x3F800001 with FP_ROUND_RNE_EN, 0x3F800000 without.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000. 0x7F800000 - 0x7F800000 (sub=1) -> 0x7FC00000, done at edge 1. 0x3F800000 + 0x00000001 (denormal) -> 0x3F800000, done at edge 1.
- 0x40400000 - 0x40400000 -> 0x00000000. 0x80000000 + 0x80000000 -> 0x80000000.
- Assert reset two cycles after capture -> done never pulses, busy=0. Then a new enable with 0x3F800000 + 0x40000000 -> 0x40400000. A second enable pulsed while busy is ignored (exactly one done).
